// File: rtl/iic_mux_n.sv
// N-channel I2C master multiplexer: tracks START/STOP on the shared bus and only
// switches channels once the bus is free, with both lines released for a guard interval.
module iic_mux_n #(
  parameter int CH_NUM    = 4,
  parameter int SEL_W     = 2,
  parameter int RST_SEL   = 0,
  parameter int IDLE_CYC  = 1000,
  parameter int GUARD_CYC = 16
) (
  input  logic              CLK_I,
  input  logic              RSTN_I,
  input  logic [SEL_W-1:0]  SEL_I,
  input  logic              SEL_REQ_I,
  output logic              SEL_ACK_O,
  output logic              SEL_ERR_O,
  output logic [SEL_W-1:0]  ACTIVE_SEL_O,
  output logic              BUSY_O,
  input  logic [CH_NUM-1:0] SDA_O_I,
  input  logic [CH_NUM-1:0] SDA_T_I,
  input  logic [CH_NUM-1:0] SCL_O_I,
  input  logic [CH_NUM-1:0] SCL_T_I,
  output logic [CH_NUM-1:0] SDA_I_O,
  output logic [CH_NUM-1:0] SCL_I_O,
  output logic              SDA_O,
  output logic              SDA_T,
  output logic              SCL_O,
  output logic              SCL_T,
  input  logic              SDA_I,
  input  logic              SCL_I
);
  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [IW-1:0]    IDLE_MAX = IW'(IDLE_CYC);
  localparam logic [GW-1:0]    GLOAD    = GW'(GUARD_CYC - 1);
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CH_NUM);
  localparam logic [SEL_W-1:0] RST_CH   = SEL_W'(RST_SEL);

  typedef enum logic [2:0] {S_CONN, S_PEND, S_GUARD, S_SWITCH, S_ACK} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  active_q, active_d, target_q, target_d, pend_sel_q, pend_sel_d;
  logic              pend_vld_q, pend_vld_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [1:0]        sda_s_q, scl_s_q;
  logic              sda_prev_q, busy_q, busy_d, err_q;

  // Bus monitor: synchronised lines, START/STOP edges and idle timeout
  logic sda_s, scl_s, start, stop, timeout, sel_ok, req_v;
  assign sda_s   = sda_s_q[1];
  assign scl_s   = scl_s_q[1];
  assign start   = sda_prev_q & ~sda_s & scl_s;
  assign stop    = ~sda_prev_q & sda_s & scl_s;
  assign timeout = (idle_q == IDLE_MAX);
  assign sel_ok  = ({1'b0, SEL_I} < CH_LIM);
  assign req_v   = SEL_REQ_I & sel_ok;

  always_comb begin
    idle_d = '0;
    if (sda_s && scl_s) idle_d = timeout ? idle_q : idle_q + 1'b1;
    busy_d = busy_q;
    if (start)                busy_d = 1'b1;
    else if (stop || timeout) busy_d = 1'b0;
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      sda_s_q    <= 2'b11;
      scl_s_q    <= 2'b11;
      sda_prev_q <= 1'b1;
      idle_q     <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sda_s_q    <= {sda_s_q[0], SDA_I};
      scl_s_q    <= {scl_s_q[0], SCL_I};
      sda_prev_q <= sda_s;
      idle_q     <= idle_d;
      busy_q     <= busy_d;
      err_q      <= SEL_REQ_I & ~sel_ok;
    end
  end

  // Channel-switch FSM
  logic [SEL_W-1:0] csel;
  assign csel = req_v ? SEL_I : pend_sel_q;

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    target_d   = target_q;
    pend_vld_d = pend_vld_q;
    pend_sel_d = pend_sel_q;
    gcnt_d     = gcnt_q;
    case (state_q)
      S_CONN: begin
        pend_vld_d = 1'b0;
        if (req_v || pend_vld_q) begin
          if (csel == active_q) state_d = S_ACK;
          else begin
            target_d = csel;
            gcnt_d   = GLOAD;
            state_d  = busy_q ? S_PEND : S_GUARD;
          end
        end
      end
      S_PEND: begin
        if (req_v) target_d = SEL_I;
        if (req_v && SEL_I == active_q) state_d = S_ACK;
        else if (!busy_q) begin
          gcnt_d  = GLOAD;
          state_d = S_GUARD;
        end
      end
      S_GUARD: begin
        if (gcnt_q == '0) state_d = S_SWITCH;
        else              gcnt_d  = gcnt_q - 1'b1;
      end
      S_SWITCH: begin
        active_d = target_q;
        state_d  = S_ACK;
      end
      S_ACK:   state_d = S_CONN;
      default: state_d = S_CONN;
    endcase
    // Requests seen while the switch is in flight wait for the next CONN cycle
    if ((state_q == S_GUARD || state_q == S_SWITCH || state_q == S_ACK) && req_v) begin
      pend_vld_d = 1'b1;
      pend_sel_d = SEL_I;
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state_q    <= S_CONN;
      active_q   <= RST_CH;
      target_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_sel_q <= '0;
      gcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      target_q   <= target_d;
      pend_vld_q <= pend_vld_d;
      pend_sel_q <= pend_sel_d;
      gcnt_q     <= gcnt_d;
    end
  end

  // Datapath: one-hot channel hit, bus released outside CONN/PEND/ACK
  logic              conn;
  logic [CH_NUM-1:0] hit;
  assign conn = (state_q == S_CONN) || (state_q == S_PEND) || (state_q == S_ACK);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign hit[i]     = (active_q == SEL_W'(i));
    assign SDA_I_O[i] = (conn && hit[i]) ? SDA_I : 1'b1;
    assign SCL_I_O[i] = (conn && hit[i]) ? SCL_I : 1'b1;
  end

  assign SDA_O = conn ? |(hit & SDA_O_I) : 1'b1;
  assign SDA_T = conn ? |(hit & SDA_T_I) : 1'b1;
  assign SCL_O = conn ? |(hit & SCL_O_I) : 1'b1;
  assign SCL_T = conn ? |(hit & SCL_T_I) : 1'b1;

  assign SEL_ACK_O    = (state_q == S_ACK);
  assign SEL_ERR_O    = err_q;
  assign ACTIVE_SEL_O = active_q;
  assign BUSY_O       = busy_q;
endmodule

// File: tb/tb_iic_mux_n.sv
// Bench for iic_mux_n: the shared bus is a wired-AND of the muxed outputs; expectations
// come from the channel-switch timing rules and a simple connected-channel model.
module tb_iic_mux_n;
  localparam int CH = 4;
  logic clk = 1'b0, rstn = 1'b0, req = 1'b0;
  logic [2:0] sel = '0;
  logic [CH-1:0] sda_o_i = '1, sda_t_i = '1, scl_o_i = '1, scl_t_i = '1;
  wire ack, err, busy, sda_o, sda_t, scl_o, scl_t;
  wire [2:0] act;
  wire [CH-1:0] sda_i_o, scl_i_o;
  wire sda_bus = sda_t | sda_o;
  wire scl_bus = scl_t | scl_o;
  int vec = 0, bad = 0;
  logic [2:0] exp_active = 3'd0;

  always #5 clk = ~clk;

  iic_mux_n #(.CH_NUM(CH), .SEL_W(3), .RST_SEL(0), .IDLE_CYC(1000), .GUARD_CYC(16)) dut (
    .CLK_I(clk), .RSTN_I(rstn), .SEL_I(sel), .SEL_REQ_I(req), .SEL_ACK_O(ack),
    .SEL_ERR_O(err), .ACTIVE_SEL_O(act), .BUSY_O(busy),
    .SDA_O_I(sda_o_i), .SDA_T_I(sda_t_i), .SCL_O_I(scl_o_i), .SCL_T_I(scl_t_i),
    .SDA_I_O(sda_i_o), .SCL_I_O(scl_i_o), .SDA_O(sda_o), .SDA_T(sda_t),
    .SCL_O(scl_o), .SCL_T(scl_t), .SDA_I(sda_bus), .SCL_I(scl_bus));

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [2:0] s);
    sel = s; req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic release_all();
    sda_o_i = '1; sda_t_i = '1; scl_o_i = '1; scl_t_i = '1;
  endtask

  task automatic test_reset();
    release_all();
    sda_t_i[0] = 1'b0; sda_o_i[0] = 1'b0;
    #3;
    vec++; if (sda_t !== 1'b0 || sda_o !== 1'b0) begin bad++; $display("FAIL reset_bus T/O got %b%b want 00", sda_t, sda_o); end
    vec++; if (sda_i_o[3:1] !== 3'b111) begin bad++; $display("FAIL reset_io got %b want 111", sda_i_o[3:1]); end
    vec++; if (act !== 3'd0 || busy !== 1'b0 || ack !== 1'b0 || err !== 1'b0)
      begin bad++; $display("FAIL reset_state act=%0d busy=%b ack=%b err=%b want 0 0 0 0", act, busy, ack, err); end
    release_all();
    tick(2);
    rstn = 1'b1;
    tick(5);
  endtask

  task automatic test_switch_idle();
    int ok_guard = 1;
    scl_t_i[0] = 1'b0; scl_o_i[0] = 1'b1;
    sda_t_i[2] = 1'b0; sda_o_i[2] = 1'b1;
    do_req(3'd2);
    for (int i = 0; i < 17; i++) begin
      if (sda_t !== 1'b1 || scl_t !== 1'b1 || sda_i_o !== 4'hF || act !== 3'd0 || ack !== 1'b0) ok_guard = 0;
      tick();
    end
    vec++; if (ok_guard == 0) begin bad++; $display("FAIL guard_release got disturbed want T=1 act=0 for 17 cycles"); end
    vec++; if (act !== 3'd2 || ack !== 1'b1) begin bad++; $display("FAIL switch_ack act=%0d ack=%b want 2 1", act, ack); end
    vec++; if (sda_t !== 1'b0 || scl_t !== 1'b1) begin bad++; $display("FAIL ch2_bus T=%b%b want 01", sda_t, scl_t); end
    tick();
    vec++; if (ack !== 1'b0) begin bad++; $display("FAIL ack_pulse got %b want 0", ack); end
    exp_active = 3'd2;
    release_all();
    tick(3);
  endtask

  task automatic test_err_same();
    int seen = 0;
    do_req(3'd5);
    vec++; if (err !== 1'b1) begin bad++; $display("FAIL err_pulse got %b want 1", err); end
    tick();
    vec++; if (err !== 1'b0) begin bad++; $display("FAIL err_single got %b want 0", err); end
    for (int i = 0; i < 20; i++) begin if (ack) seen++; tick(); end
    vec++; if (seen != 0 || act !== exp_active) begin bad++; $display("FAIL err_noack acks=%0d act=%0d want 0 %0d", seen, act, exp_active); end
    do_req(exp_active);
    seen = 0;
    for (int i = 0; i < 2; i++) begin if (ack) seen++; tick(); end
    vec++; if (seen != 1 || act !== exp_active) begin bad++; $display("FAIL same_ack acks=%0d act=%0d want 1 %0d", seen, act, exp_active); end
  endtask

  task automatic test_random_dp();
    logic et, eo, ct, co;
    logic [CH-1:0] eio, cio;
    for (int it = 0; it < 30; it++) begin
      sda_t_i = CH'($urandom); sda_o_i = CH'($urandom);
      scl_t_i = CH'($urandom); scl_o_i = CH'($urandom);
      tick();
      et = sda_t_i[exp_active]; eo = sda_o_i[exp_active];
      ct = scl_t_i[exp_active]; co = scl_o_i[exp_active];
      eio = '1; cio = '1;
      eio[exp_active] = et | eo;
      cio[exp_active] = ct | co;
      vec++;
      if ({sda_t, sda_o, scl_t, scl_o} !== {et, eo, ct, co} || sda_i_o !== eio || scl_i_o !== cio) begin
        bad++;
        $display("FAIL dp_%0d bus=%b io=%b/%b want bus=%b io=%b/%b", it,
                 {sda_t, sda_o, scl_t, scl_o}, sda_i_o, scl_i_o, {et, eo, ct, co}, eio, cio);
      end
    end
    release_all();
    tick(4);
    sda_t_i[exp_active] = 1'b0; sda_o_i[exp_active] = 1'b0;
    tick(4);
    release_all();
    tick(5);
    vec++; if (busy !== 1'b0) begin bad++; $display("FAIL dp_cleanup busy=%b want 0", busy); end
  endtask

  task automatic test_random_switch();
    logic [2:0] s;
    int first, errs, want;
    for (int it = 0; it < 8; it++) begin
      s = 3'($urandom_range(0, 7));
      do_req(s);
      first = -1; errs = 0;
      for (int n = 0; n < 25; n++) begin
        if (n > 0) tick();
        if (ack && first < 0) first = n;
        if (err) errs++;
        if (n == 8 && s < CH && s != exp_active) begin
          vec++; if (sda_t !== 1'b1 || scl_t !== 1'b1) begin bad++; $display("FAIL rs_guard_%0d T=%b%b want 11", it, sda_t, scl_t); end
        end
      end
      want = (s >= CH) ? -1 : (s == exp_active) ? 0 : 17;
      if (s < CH) exp_active = s;
      vec++;
      if (first != want || errs != ((s >= CH) ? 1 : 0) || act !== exp_active) begin
        bad++;
        $display("FAIL rs_%0d sel=%0d ack_at=%0d errs=%0d act=%0d want %0d %0d %0d",
                 it, s, first, errs, act, want, (s >= CH) ? 1 : 0, exp_active);
      end
    end
  endtask

  task automatic test_pend();
    logic [2:0] own, tgt;
    int ok = 1, n;
    own = exp_active; tgt = 3'((exp_active + 1) % CH);
    sda_t_i[own] = 1'b0; sda_o_i[own] = 1'b0;
    tick(5);
    vec++; if (busy !== 1'b1) begin bad++; $display("FAIL pend_start busy=%b want 1", busy); end
    do_req(tgt);
    for (int i = 0; i < 10; i++) begin
      if (ack !== 1'b0 || act !== own || sda_t !== 1'b0) ok = 0;
      tick();
    end
    vec++; if (ok == 0) begin bad++; $display("FAIL pend_hold act=%0d ack=%b T=%b want %0d 0 0", act, ack, sda_t, own); end
    sda_t_i[own] = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 10) begin
        vec++; if (sda_t !== 1'b1 || scl_t !== 1'b1) begin bad++; $display("FAIL pend_guard T=%b%b want 11", sda_t, scl_t); end
      end
      if (ack) begin n = i; break; end
    end
    vec++; if (n < 19 || n > 23 || act !== tgt) begin bad++; $display("FAIL pend_ack at=%0d act=%0d want 19..23 %0d", n, act, tgt); end
    exp_active = tgt;
    tick(3);
  endtask

  task automatic test_timeout();
    logic [2:0] own, tgt;
    int n = 0, m = 0;
    own = exp_active; tgt = (own == 3'd3) ? 3'd2 : 3'd3;
    sda_t_i[own] = 1'b0; sda_o_i[own] = 1'b0;
    tick(5);
    vec++; if (busy !== 1'b1) begin bad++; $display("FAIL to_start busy=%b want 1", busy); end
    scl_t_i[own] = 1'b0; scl_o_i[own] = 1'b0; tick(3);
    sda_t_i[own] = 1'b1; tick(3);
    do_req(tgt);
    tick(2);
    scl_t_i[own] = 1'b1;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (i == 990) begin
        vec++; if (busy !== 1'b1) begin bad++; $display("FAIL to_early busy=%b want 1", busy); end
      end
      if (!busy) begin n = i; break; end
    end
    vec++; if (n < 1000 || n > 1006) begin bad++; $display("FAIL to_busy drop_at=%0d want 1000..1006", n); end
    for (int i = 1; i <= 30; i++) begin tick(); if (ack) begin m = i; break; end end
    vec++; if (m == 0 || act !== tgt) begin bad++; $display("FAIL to_ack at=%0d act=%0d want ack act=%0d", m, act, tgt); end
    exp_active = tgt;
    tick(3);
  endtask

  task automatic test_reset_guard();
    logic [2:0] tgt;
    int seen = 0;
    tgt = (exp_active == 3'd1) ? 3'd2 : 3'd1;
    scl_t_i[0] = 1'b0; scl_o_i[0] = 1'b1;
    do_req(tgt);
    tick(5);
    vec++; if (scl_t !== 1'b1) begin bad++; $display("FAIL rg_guard T=%b want 1", scl_t); end
    rstn = 1'b0;
    #1;
    vec++; if (act !== 3'd0 || scl_t !== 1'b0) begin bad++; $display("FAIL rg_async act=%0d T=%b want 0 0", act, scl_t); end
    tick(2);
    rstn = 1'b1;
    for (int i = 0; i < 30; i++) begin if (ack) seen++; tick(); end
    vec++; if (seen != 0 || act !== 3'd0) begin bad++; $display("FAIL rg_noack acks=%0d act=%0d want 0 0", seen, act); end
  endtask

  initial begin
    test_reset();
    test_switch_idle();
    test_err_same();
    test_random_dp();
    test_random_switch();
    test_pend();
    test_timeout();
    test_reset_guard();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
